// File: rtl/reg_dump_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_scanner
//  Purpose  : Debug-side reader for the pipeline register-inspection port.
//             On a start pulse, sweeps the PC and R0..R(NUM_REGS-1). Each
//             value is emitted as a tagged 32-bit word on a valid/ready
//             stream.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_scanner #(
  parameter int NUM_REGS   = 32,  // registers swept, R0 upward (1..32)
  parameter int INCLUDE_PC = 1,   // 1: PC word emitted before R0
  parameter int SETTLE     = 1    // cycles regSel is held before sampling (1..7)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pcIn,
  input  logic [31:0] regData,
  output logic [4:0]  regSel,
  output logic [31:0] outData,
  output logic [5:0]  outIndex,
  output logic        outValid,
  input  logic        outReady,
  output logic        outLast,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [2:0] C_SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [4:0] C_LAST_REG    = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  sel_q,   sel_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [31:0] data_q,  data_d;
  logic [5:0]  index_q, index_d;
  logic        valid_q, valid_d;
  logic        last_q,  last_d;

  // Next-state and datapath: each register is sampled at the end of its own
  // settle window, so the dump is a rolling (non-atomic) snapshot.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = 5'd0;
        if (start) begin
          if (INCLUDE_PC != 0) begin
            data_d  = pcIn;
            index_d = 6'd0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            state_d = ST_SEND;
          end else begin
            cnt_d   = 3'd0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == C_SETTLE_LAST) begin
          data_d  = regData;
          index_d = {1'b0, sel_q} + 6'd1;
          valid_d = 1'b1;
          last_d  = (sel_q == C_LAST_REG);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Word is held untouched until the consumer takes it.
        if (outReady) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            // After the PC word the first register is R0, already selected.
            sel_d   = (index_q == 6'd0) ? 5'd0 : sel_q + 5'd1;
            cnt_d   = 3'd0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_FIN: begin
        sel_d   = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a sweep in flight is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 5'd0;
      cnt_q   <= 3'd0;
      data_q  <= 32'd0;
      index_q <= 6'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign regSel   = sel_q;
  assign outData  = data_q;
  assign outIndex = index_q;
  assign outValid = valid_q;
  assign outLast  = last_q;
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign done     = (state_q == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_scanner
//  Purpose  : Self-checking bench for reg_dump_scanner. Instance A uses the
//             default parameters; instance B uses INCLUDE_PC=0, NUM_REGS=4,
//             SETTLE=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_dump_scanner;

  localparam int NUM_A    = 32;
  localparam int SETTLE_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        rst_a, start_a, ready_a;
  logic [31:0] pc_a, rd_a, data_a;
  logic [4:0]  sel_a;
  logic [5:0]  idx_a;
  logic        valid_a, last_a, busy_a, done_a;
  logic [31:0] regs_a [32];
  assign rd_a = regs_a[sel_a];

  // Instance B: no PC, 4 registers, 3-cycle settle
  logic        rst_b, start_b, ready_b;
  logic [31:0] pc_b, rd_b, data_b;
  logic [4:0]  sel_b;
  logic [5:0]  idx_b;
  logic        valid_b, last_b, busy_b, done_b;
  logic [31:0] regs_b [32];
  assign rd_b = regs_b[sel_b];

  reg_dump_scanner u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .pcIn(pc_a), .regData(rd_a),
    .regSel(sel_a), .outData(data_a), .outIndex(idx_a), .outValid(valid_a),
    .outReady(ready_a), .outLast(last_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_scanner #(.NUM_REGS(4), .INCLUDE_PC(0), .SETTLE(3)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .pcIn(pc_b), .regData(rd_b),
    .regSel(sel_b), .outData(data_b), .outIndex(idx_b), .outValid(valid_b),
    .outReady(ready_b), .outLast(last_b), .busy(busy_b), .done(done_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Table vectors for instance B: inputs driven for one edge, outputs
  // expected after that edge. sel < 0 means regSel is not checked.
  typedef struct {
    bit          rst;
    bit          start;
    bit          rdy;
    bit          v;
    bit          busy;
    bit          done;
    bit          last;
    int          sel;
    logic [5:0]  idx;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(bit rst, bit st, bit rdy, bit v, bit bsy, bit dn,
                              bit lst, int sel, logic [5:0] idx, logic [31:0] dat);
    vec_t r;
    r.rst = rst; r.start = st; r.rdy = rdy; r.v = v; r.busy = bsy; r.done = dn;
    r.last = lst; r.sel = sel; r.idx = idx; r.data = dat;
    return r;
  endfunction

  // Expected stream word of the reference model
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    bit          last;
  } word_t;

  // One sweep on instance A against a word-list model. The model knows only
  // the external rules: word order, per-word latency (1 cycle after start
  // for the PC, SETTLE+1 after each handshake) and hold-until-accepted.
  // rdy_mode: 0 always ready, 1 random, 2 stall 5 cycles on tag 4.
  task automatic sweep_a(input int rdy_mode, input bit fixed, input int restart_at,
                         input int reset_at, input bit fin_start, input bit timing);
    word_t       q[$];
    int          gap, lat, cyc, words, bp_left;
    bit          prev_v, exp_v;
    logic [4:0]  sel_exp;
    pc_a = fixed ? 32'h0000_0040 : $urandom;
    for (int k = 0; k < 32; k++) regs_a[k] = fixed ? (32'h100 + 32'(k)) : $urandom;
    q.push_back('{6'd0, pc_a, 1'b0});
    for (int k = 0; k < NUM_A; k++) q.push_back('{6'(k + 1), regs_a[k], (k == NUM_A - 1)});
    start_a = 1'b1;
    ready_a = 1'b1;
    lat = 1; gap = 0; cyc = 0; words = 0; bp_left = 5; prev_v = 1'b0;
    for (int guard = 0; guard < 3000; guard++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) gap = 1;
      else if (prev_v && ready_a) begin
        void'(q.pop_front());
        words++;
        gap = 1;
        lat = SETTLE_A + 1;
      end else gap++;
      start_a = (cyc == restart_at);
      if (q.size() == 0) begin
        chk("fin_done", done_a, 1'b1);
        chk("fin_busy", busy_a, 1'b0);
        chk("fin_valid", valid_a, 1'b0);
        chk("word_count", words, NUM_A + 1);
        if (timing) chk("done_cycle", cyc, 66);
        start_a = fin_start;
        @(negedge clk);
        chk("idle_done", done_a, 1'b0);
        chk("idle_busy", busy_a, 1'b0);
        chk("idle_valid", valid_a, 1'b0);
        start_a = 1'b0;
        return;
      end
      exp_v   = (gap >= lat);
      sel_exp = (q[0].idx == 6'd0) ? 5'd0 : 5'(q[0].idx - 6'd1);
      chk("valid", valid_a, exp_v);
      chk("busy", busy_a, 1'b1);
      chk("done", done_a, 1'b0);
      chk("regsel", sel_a, sel_exp);
      if (exp_v) begin
        chk("index", idx_a, q[0].idx);
        chk("data", data_a, q[0].data);
        chk("last", last_a, q[0].last);
        if (timing && q[0].last) chk("last_cycle", cyc, 65);
      end else begin
        chk("last_idle", last_a, 1'b0);
      end
      if (reset_at > 0 && cyc >= reset_at && exp_v) begin
        rst_a = 1'b1;
        start_a = 1'b0;
        @(negedge clk);
        chk("rst_sel", sel_a, 5'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_index", idx_a, 6'd0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_last", last_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        rst_a = 1'b0;
        return;
      end
      case (rdy_mode)
        0: ready_a = 1'b1;
        1: ready_a = ($urandom_range(0, 3) != 0);
        default: begin
          if (exp_v && q[0].idx == 6'd4 && bp_left > 0) begin
            ready_a = 1'b0;
            bp_left--;
          end else ready_a = 1'b1;
        end
      endcase
      prev_v = exp_v;
    end
    chk("sweep_timeout_words_left", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; start_a = 1'b0; ready_a = 1'b1; pc_a = 32'd0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b1; pc_b = 32'hDEAD_BEEF;
    for (int k = 0; k < 32; k++) begin
      regs_a[k] = 32'd0;
      regs_b[k] = 32'h100 + 32'(k);
    end

    // Rows: rst, start, rdy | valid, busy, done, last, sel, idx, data
    tbl[0]  = mk(0, 1, 1, 0, 1, 0, 0,  0, 6'd0, 32'h0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 0, 0,  0, 6'd0, 32'h0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 0, 0,  0, 6'd0, 32'h0);
    tbl[3]  = mk(0, 0, 1, 1, 1, 0, 0,  0, 6'd1, 32'h100);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0,  0, 6'd1, 32'h100);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0, 0,  0, 6'd1, 32'h100);
    tbl[6]  = mk(0, 0, 1, 0, 1, 0, 0,  1, 6'd0, 32'h0);
    tbl[7]  = mk(0, 1, 1, 0, 1, 0, 0,  1, 6'd0, 32'h0);
    tbl[8]  = mk(0, 0, 1, 0, 1, 0, 0,  1, 6'd0, 32'h0);
    tbl[9]  = mk(0, 0, 1, 1, 1, 0, 0,  1, 6'd2, 32'h101);
    tbl[10] = mk(0, 0, 1, 0, 1, 0, 0,  2, 6'd0, 32'h0);
    tbl[11] = mk(0, 0, 1, 0, 1, 0, 0,  2, 6'd0, 32'h0);
    tbl[12] = mk(0, 0, 1, 0, 1, 0, 0,  2, 6'd0, 32'h0);
    tbl[13] = mk(0, 0, 1, 1, 1, 0, 0,  2, 6'd3, 32'h102);
    tbl[14] = mk(0, 0, 1, 0, 1, 0, 0,  3, 6'd0, 32'h0);
    tbl[15] = mk(0, 0, 1, 0, 1, 0, 0,  3, 6'd0, 32'h0);
    tbl[16] = mk(0, 0, 1, 0, 1, 0, 0,  3, 6'd0, 32'h0);
    tbl[17] = mk(0, 0, 1, 1, 1, 0, 1,  3, 6'd4, 32'h103);
    tbl[18] = mk(0, 0, 1, 0, 0, 1, 0, -1, 6'd0, 32'h0);
    tbl[19] = mk(0, 1, 1, 0, 0, 0, 0,  0, 6'd0, 32'h0);
    tbl[20] = mk(0, 1, 1, 0, 1, 0, 0,  0, 6'd0, 32'h0);
    tbl[21] = mk(0, 0, 1, 0, 1, 0, 0,  0, 6'd0, 32'h0);
    tbl[22] = mk(1, 0, 1, 0, 0, 0, 0,  0, 6'd0, 32'h0);
    tbl[23] = mk(0, 1, 1, 0, 1, 0, 0,  0, 6'd0, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset_sel", sel_a, 5'd0);
    chk("reset_data", data_a, 32'd0);
    chk("reset_index", idx_a, 6'd0);
    chk("reset_valid", valid_a, 1'b0);
    chk("reset_last", last_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Table-driven run on instance B
    for (int i = 0; i < 24; i++) begin
      rst_b   = tbl[i].rst;
      start_b = tbl[i].start;
      ready_b = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("b_valid[%0d]", i), valid_b, tbl[i].v);
      chk($sformatf("b_busy[%0d]", i), busy_b, tbl[i].busy);
      chk($sformatf("b_done[%0d]", i), done_b, tbl[i].done);
      chk($sformatf("b_last[%0d]", i), last_b, tbl[i].last);
      if (tbl[i].sel >= 0) chk($sformatf("b_sel[%0d]", i), sel_b, 5'(tbl[i].sel));
      if (tbl[i].v) begin
        chk($sformatf("b_index[%0d]", i), idx_b, tbl[i].idx);
        chk($sformatf("b_data[%0d]", i), data_b, tbl[i].data);
      end
    end
    rst_b = 1'b1;
    start_b = 1'b0;

    // Instance A: hand-written corner sequences, then random sweeps
    sweep_a(0, 1'b1, 0, 0, 1'b0, 1'b1);   // cycle-exact default sweep
    sweep_a(2, 1'b1, 0, 0, 1'b0, 1'b0);   // stall on tag 4
    sweep_a(0, 1'b0, 10, 0, 1'b0, 1'b1);  // start again at cycle 10
    sweep_a(0, 1'b0, 0, 7, 1'b0, 1'b0);   // reset while a word is valid
    sweep_a(0, 1'b1, 0, 0, 1'b1, 1'b1);   // full sweep after reset, start in FIN
    sweep_a(0, 1'b0, 0, 0, 1'b0, 1'b1);   // sweep right after the FIN start
    for (int n = 0; n < 6; n++) begin
      sweep_a(1, 1'b0, int'($urandom_range(2, 40)), 0, 1'(n % 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_dump_scanner.md
Name: reg_dump_scanner

Overview:
- Debug-side reader for the pipeline's register-inspection port: drives the register select (regIn), samples the returned value (regOut), and snapshots the PC (pcOut).
- On a start pulse, sweeps PC plus R0..R(NUM_REGS-1) and emits each as a 32-bit word on a valid/ready stream.
- The stream feeds the board-level transmitter / display sequencer.
- Sits outside the pipeline, clocked by the same clk; the pipeline keeps running during a sweep.

Parameters:
- NUM_REGS, 32, number of registers swept, R0 upward; legal 1..32.
- INCLUDE_PC, 1, 1 = PC word emitted first; 0 = sweep starts at R0.
- SETTLE, 1, cycles regSel is held stable before regData is sampled; legal 1..7.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; ignored while busy.
- pcIn  in  32  pipeline PC (pcOut).
- regData  in  32  register value for regSel (regOut), combinational from the register file.
- regSel  out  5  register index driven to the pipeline (regIn).
- outData  out  32  stream word.
- outIndex  out  6  word tag: 0 = PC, 1+r = register r.
- outValid  out  1  outData/outIndex/outLast valid.
- outReady  in  1  consumer accepts the word when outValid && outReady.
- outLast  out  1  marks the final word of a sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (synchronous, active-high, highest priority, any state): state IDLE.
  - regSel=0, outData=0, outIndex=0.
  - outValid=0, outLast=0, busy=0, done=0, settle counter=0.
  - A partially sent sweep is abandoned; no done pulse.
- FSM states: IDLE, WAIT, SEND, FIN.
- IDLE:
  - regSel=0, busy=0.
  - start=1 with INCLUDE_PC=1: capture pcIn into outData, outIndex=0, outValid=1, go to SEND.
  - start=1 with INCLUDE_PC=0: regSel=0, counter=0, go to WAIT.
  - busy=1 from the cycle after start.
- WAIT:
  - regSel is held at the current register r; counter increments each cycle.
  - On the cycle where counter==SETTLE-1: capture regData into outData, outIndex=r+1, outValid=1, go to SEND.
  - WAIT therefore lasts exactly SETTLE cycles.
- SEND:
  - outData, outIndex and outLast are held stable while outValid && !outReady.
  - outLast=1 iff the word is R(NUM_REGS-1).
  - On handshake of a non-last word: outValid=0, regSel=next register (0 after the PC word), counter=0, go to WAIT.
  - On handshake of the last word: outValid=0, outLast=0, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE. A start in FIN is ignored.
- start while busy (WAIT/SEND/FIN): ignored, not queued.
- Latency with outReady held at 1:
  - PC word valid 1 cycle after the start cycle.
  - Each register word valid SETTLE+1 cycles after the previous handshake.
  - Words per sweep = NUM_REGS + INCLUDE_PC.
- The snapshot is not atomic: each register is sampled at its own WAIT end.
- R0 is reported as whatever regData returns (expected 0); no special-casing.
- outIndex is 6 bits, so 32 registers plus PC (max tag 32) fits without wrap.

Test Plan:
- Defaults, outReady=1, start at cycle 0 with pcIn=0x0000_0040 and Rk preloaded to 0x100+k:
  - PC word 0x40, tag 0, valid at cycle 1.
  - R0..R31 follow every 2 cycles with tags 1..32.
  - outLast with tag 32 at cycle 65; done at cycle 66.
- Backpressure: outReady low for 5 cycles while the R3 word (tag 4) is valid -> outData/outIndex stable all 5 cycles, regSel stays 3, no word lost or duplicated.
- INCLUDE_PC=0, NUM_REGS=4, SETTLE=3:
  - regSel steps 0,1,2,3; each word appears 4 cycles after the previous handshake.
  - Tags 1..4; outLast on tag 4.
- start pulsed again at cycle 10 of a sweep -> ignored; exactly 33 words and a single done.
- reset asserted in SEND with outValid=1 -> next cycle all outputs 0, state IDLE; a new start yields a full, correct sweep from the PC word.
- start asserted in the FIN (done) cycle -> ignored; start one cycle later begins a new sweep normally.
